// File: rtl/shiftreg_universal_param_if.sv
// Control/data bundle for the universal shift register: master drives ops, slave returns state.
// Pure wiring, no latency; no backpressure, the en signal is the only flow control.
interface shiftreg_universal_param_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                   en;
  logic [2:0]             mode;
  logic [WIDTH-1:0]       sin_r;
  logic [WIDTH-1:0]       sin_l;
  logic [WIDTH*DEPTH-1:0] pload;
  logic [WIDTH*DEPTH-1:0] q;
  logic [WIDTH-1:0]       sout_r;
  logic [WIDTH-1:0]       sout_l;
  logic [CW-1:0]          fill;
  logic                   full;

  modport master (
    output en, mode, sin_r, sin_l, pload,
    input  q, sout_r, sout_l, fill, full
  );

  modport slave (
    input  en, mode, sin_r, sin_l, pload,
    output q, sout_r, sout_l, fill, full
  );
endinterface

// File: rtl/shiftreg_universal_param.sv
// DEPTH x WIDTH universal shift register (shift/rotate/load/clear) with saturating fill count.
// All outputs registered, one edge per operation; no backpressure, en=0 holds everything.
module shiftreg_universal_param #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        clear,
  shiftreg_universal_param_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int N  = WIDTH * DEPTH;

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SHR  = 3'b001,
    M_SHL  = 3'b010,
    M_ROR  = 3'b011,
    M_ROL  = 3'b100,
    M_LOAD = 3'b101,
    M_CLR  = 3'b110,
    M_RSVD = 3'b111
  } mode_e;

  logic [N-1:0]  r_q;
  logic [CW-1:0] r_fill;
  logic          r_full;

  logic [N-1:0]  w_q_nxt;
  logic [CW-1:0] w_fill_nxt;
  logic [CW-1:0] w_fill_inc;

  // Saturates at DEPTH so a long delay-line run never wraps back to empty.
  assign w_fill_inc = (r_fill == CW'(DEPTH)) ? r_fill : r_fill + 1'b1;

  always_comb begin
    w_q_nxt    = r_q;
    w_fill_nxt = r_fill;
    if (bus.en) begin
      case (mode_e'(bus.mode))
        M_SHR: begin
          w_q_nxt    = {bus.sin_r, r_q[N-1:WIDTH]};
          w_fill_nxt = w_fill_inc;
        end
        M_SHL: begin
          w_q_nxt    = {r_q[N-WIDTH-1:0], bus.sin_l};
          w_fill_nxt = w_fill_inc;
        end
        M_ROR:  w_q_nxt = {r_q[WIDTH-1:0], r_q[N-1:WIDTH]};
        M_ROL:  w_q_nxt = {r_q[N-WIDTH-1:0], r_q[N-1 -: WIDTH]};
        M_LOAD: begin
          w_q_nxt    = bus.pload;
          w_fill_nxt = CW'(DEPTH);
        end
        M_CLR: begin
          w_q_nxt    = '0;
          w_fill_nxt = '0;
        end
        default: ; // hold and the reserved code both leave state untouched
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_q    <= '0;
      r_fill <= '0;
      r_full <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_fill <= w_fill_nxt;
      r_full <= (w_fill_nxt == CW'(DEPTH));
    end
  end

  assign bus.q      = r_q;
  assign bus.sout_r = r_q[WIDTH-1:0];
  assign bus.sout_l = r_q[N-1 -: WIDTH];
  assign bus.fill   = r_fill;
  assign bus.full   = r_full;
endmodule

// File: tb/tb_shiftreg_universal_param.sv
// Scoreboarded directed test of shiftreg_universal_param at 4x4 and 1x8 geometries.
module tb_shiftreg_universal_param;
  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  shiftreg_universal_param_if #(.WIDTH(4), .DEPTH(4)) bus ();
  shiftreg_universal_param_if #(.WIDTH(1), .DEPTH(8)) bus8 ();

  shiftreg_universal_param #(.WIDTH(4), .DEPTH(4)) dut (
    .clock(clock), .clear(clear), .bus(bus)
  );
  shiftreg_universal_param #(.WIDTH(1), .DEPTH(8)) dut8 (
    .clock(clock), .clear(clear), .bus(bus8)
  );

  typedef struct packed {
    logic [15:0] q;
    logic [3:0]  sr;
    logic [3:0]  sl;
    logic [2:0]  fill;
    logic        full;
  } exp4_t;

  typedef struct packed {
    logic [7:0] q;
    logic       sr;
    logic       sl;
    logic [3:0] fill;
    logic       full;
  } exp8_t;

  exp4_t sb4[$];
  string nm4[$];
  exp8_t sb8[$];
  string nm8[$];
  int total = 0;
  int bad   = 0;

  task automatic push4(input string n, input logic [15:0] eq, input logic [2:0] ef);
    exp4_t e;
    e.q = eq; e.sr = eq[3:0]; e.sl = eq[15:12]; e.fill = ef; e.full = (ef == 3'd4);
    sb4.push_back(e);
    nm4.push_back(n);
  endtask

  task automatic push8(input string n, input logic [7:0] eq, input logic [3:0] ef);
    exp8_t e;
    e.q = eq; e.sr = eq[0]; e.sl = eq[7]; e.fill = ef; e.full = (ef == 4'd8);
    sb8.push_back(e);
    nm8.push_back(n);
  endtask

  task automatic step4(input string n, input logic e, input logic [2:0] m,
                       input logic [3:0] sr, input logic [3:0] sl, input logic [15:0] pl,
                       input logic [15:0] eq, input logic [2:0] ef);
    bus.en = e; bus.mode = m; bus.sin_r = sr; bus.sin_l = sl; bus.pload = pl;
    @(posedge clock);
    #1;
    push4(n, eq, ef);
  endtask

  task automatic step8(input string n, input logic b, input logic [7:0] eq, input logic [3:0] ef);
    bus8.en = 1'b1; bus8.mode = 3'b001; bus8.sin_r = b;
    @(posedge clock);
    #1;
    push8(n, eq, ef);
  endtask

  // Monitors: one expected record per falling edge, when one is pending.
  initial begin
    exp4_t e;
    string n;
    forever begin
      @(negedge clock);
      if (sb4.size() != 0) begin
        e = sb4.pop_front();
        n = nm4.pop_front();
        total++;
        if ({bus.q, bus.sout_r, bus.sout_l, bus.fill, bus.full} !== e) begin
          bad++;
          $display("FAIL %s: got q=%h sr=%h sl=%h fill=%0d full=%b, want q=%h sr=%h sl=%h fill=%0d full=%b",
                   n, bus.q, bus.sout_r, bus.sout_l, bus.fill, bus.full,
                   e.q, e.sr, e.sl, e.fill, e.full);
        end
      end
    end
  end

  initial begin
    exp8_t e;
    string n;
    forever begin
      @(negedge clock);
      if (sb8.size() != 0) begin
        e = sb8.pop_front();
        n = nm8.pop_front();
        total++;
        if ({bus8.q, bus8.sout_r, bus8.sout_l, bus8.fill, bus8.full} !== e) begin
          bad++;
          $display("FAIL %s: got q=%b sr=%b sl=%b fill=%0d full=%b, want q=%b sr=%b sl=%b fill=%0d full=%b",
                   n, bus8.q, bus8.sout_r, bus8.sout_l, bus8.fill, bus8.full,
                   e.q, e.sr, e.sl, e.fill, e.full);
        end
      end
    end
  end

  initial begin
    bus.en = 1'b0; bus.mode = 3'b000; bus.sin_r = '0; bus.sin_l = '0; bus.pload = '0;
    bus8.en = 1'b0; bus8.mode = 3'b000; bus8.sin_r = '0; bus8.sin_l = '0; bus8.pload = '0;
    #1;
    push4("reset", 16'h0000, 3'd0);
    push8("reset8", 8'h00, 4'd0);
    @(negedge clock);
    #2 clear = 1'b1;

    // Shift right: D enters stage 3 and reaches sout_r on the fourth edge.
    step4("shr1", 1'b1, 3'b001, 4'hD, 4'h0, 16'h0, 16'hD000, 3'd1);
    step4("shr2", 1'b1, 3'b001, 4'h0, 4'h0, 16'h0, 16'h0D00, 3'd2);
    step4("shr3", 1'b1, 3'b001, 4'h0, 4'h0, 16'h0, 16'h00D0, 3'd3);
    step4("shr4", 1'b1, 3'b001, 4'h0, 4'h0, 16'h0, 16'h000D, 3'd4);
    step4("shr5", 1'b1, 3'b001, 4'h0, 4'h0, 16'h0, 16'h0000, 3'd4);

    step4("load",  1'b1, 3'b101, 4'h0, 4'h0, 16'h1234, 16'h1234, 3'd4);
    step4("ror",   1'b1, 3'b011, 4'h0, 4'h0, 16'h0,    16'h4123, 3'd4);
    step4("rol",   1'b1, 3'b100, 4'h0, 4'h0, 16'h0,    16'h1234, 3'd4);
    step4("shl",   1'b1, 3'b010, 4'h0, 4'hF, 16'h0,    16'h234F, 3'd4);
    for (int i = 0; i < 3; i++)
      step4("en_off", 1'b0, 3'b001, 4'hA, 4'hB, 16'hFFFF, 16'h234F, 3'd4);
    step4("rsvd",  1'b1, 3'b111, 4'hA, 4'hB, 16'hFFFF, 16'h234F, 3'd4);
    step4("hold",  1'b1, 3'b000, 4'hA, 4'hB, 16'hFFFF, 16'h234F, 3'd4);
    step4("sclr",  1'b1, 3'b110, 4'hA, 4'hB, 16'hFFFF, 16'h0000, 3'd0);
    step4("shl_f", 1'b1, 3'b010, 4'h0, 4'h7, 16'h0,    16'h0007, 3'd1);

    // Asynchronous clear pulse that ends before the next edge; en=0 at that edge proves no edge was needed.
    step4("load2", 1'b1, 3'b101, 4'h0, 4'h0, 16'h1234, 16'h1234, 3'd4);
    @(negedge clock);
    #1;
    bus.en = 1'b0;
    clear = 1'b0;
    #2;
    clear = 1'b1;
    push4("async_clear", 16'h0000, 3'd0);
    @(negedge clock);
    step4("post_clear", 1'b1, 3'b001, 4'hA, 4'h0, 16'h0, 16'hA000, 3'd1);
    bus.en = 1'b0;

    step8("bit1", 1'b1, 8'b1000_0000, 4'd1);
    step8("bit2", 1'b0, 8'b0100_0000, 4'd2);
    step8("bit3", 1'b1, 8'b1010_0000, 4'd3);
    step8("bit4", 1'b1, 8'b1101_0000, 4'd4);
    step8("bit5", 1'b0, 8'b0110_1000, 4'd5);
    step8("bit6", 1'b0, 8'b0011_0100, 4'd6);
    step8("bit7", 1'b1, 8'b1001_1010, 4'd7);
    step8("bit8", 1'b0, 8'b0100_1101, 4'd8);
    step8("bit9", 1'b1, 8'b1010_0110, 4'd8);
    bus8.en = 1'b0;

    repeat (2) @(negedge clock);
    #1;
    total++;
    if (sb4.size() + sb8.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", sb4.size() + sb8.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
